// File: rtl/generic_table_store.sv
// generic_table_store: single-port table RAM serving fixed-latency datapath lookups (highest priority)
// and req/ack register reads/writes. Define TABLE_STORE_PARITY_EN to store and check even parity per entry.
module generic_table_store #(
  parameter int TABLE_ENTRY_WIDTH = 8,
  parameter int TABLE_ADDR_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         table_rd_req,
  output logic                         table_rd_ack,
  input  logic [TABLE_ADDR_WIDTH-1:0]  table_rd_addr,
  output logic [TABLE_ENTRY_WIDTH-1:0] table_rd_data,
  input  logic                         table_wr_req,
  output logic                         table_wr_ack,
  input  logic [TABLE_ADDR_WIDTH-1:0]  table_wr_addr,
  input  logic [TABLE_ENTRY_WIDTH-1:0] table_wr_data,
  input  logic                         lookup_req,
  input  logic [TABLE_ADDR_WIDTH-1:0]  lookup_addr,
  output logic                         lookup_ack,
  output logic [TABLE_ENTRY_WIDTH-1:0] lookup_data,
  output logic                         init_done,
  output logic                         parity_err
);

`ifdef TABLE_STORE_PARITY_EN
  localparam int RAM_W = TABLE_ENTRY_WIDTH + 1;
`else
  localparam int RAM_W = TABLE_ENTRY_WIDTH;
`endif
  localparam int                          DEPTH    = 1 << TABLE_ADDR_WIDTH;
  localparam logic [TABLE_ADDR_WIDTH-1:0] LAST_IDX = {TABLE_ADDR_WIDTH{1'b1}};
  localparam logic [TABLE_ADDR_WIDTH-1:0] IDX_ONE  = {{(TABLE_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic logic even_parity(input logic [TABLE_ENTRY_WIDTH-1:0] d);
    return ^d;
  endfunction

  function automatic logic [RAM_W-1:0] make_word(input logic [TABLE_ENTRY_WIDTH-1:0] d);
`ifdef TABLE_STORE_PARITY_EN
    return {even_parity(d), d};
`else
    return d;
`endif
  endfunction

  state_t                        state_r;
  logic [TABLE_ADDR_WIDTH-1:0]   clear_idx_r;
  logic                          wr_disarm_r;
  logic                          rd_disarm_r;
  logic [RAM_W-1:0]              mem_r [DEPTH];

  logic                          wr_pending_s;
  logic                          rd_pending_s;
  logic                          lookup_grant_s;
  logic                          wr_grant_s;
  logic                          rd_grant_s;
  logic                          ram_we_s;
  logic [TABLE_ADDR_WIDTH-1:0]   ram_addr_s;
  logic [RAM_W-1:0]              ram_wdata_s;
  logic [RAM_W-1:0]              rd_word_s;

  // A request type stays disarmed after its ack until its req is seen low.
  assign wr_pending_s = table_wr_req && !wr_disarm_r;
  assign rd_pending_s = table_rd_req && !rd_disarm_r;
  assign rd_word_s    = mem_r[ram_addr_s];

  // Single RAM port arbitration: clear sweep, else lookup > write > read.
  always_comb begin
    lookup_grant_s = 1'b0;
    wr_grant_s     = 1'b0;
    rd_grant_s     = 1'b0;
    ram_we_s       = 1'b0;
    ram_addr_s     = lookup_addr;
    ram_wdata_s    = make_word({TABLE_ENTRY_WIDTH{1'b0}});
    if (reset) begin
      ram_we_s = 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          ram_we_s   = 1'b1;
          ram_addr_s = clear_idx_r;
        end
        ST_IDLE: begin
          if (lookup_req) begin
            lookup_grant_s = 1'b1;
            ram_addr_s     = lookup_addr;
          end else if (wr_pending_s) begin
            wr_grant_s  = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = table_wr_addr;
            ram_wdata_s = make_word(table_wr_data);
          end else if (rd_pending_s) begin
            rd_grant_s = 1'b1;
            ram_addr_s = table_rd_addr;
          end else begin
            ram_addr_s = lookup_addr;
          end
        end
        default: begin
          ram_we_s = 1'b0;
        end
      endcase
    end
  end

  // Table storage write port.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_addr_s] <= ram_wdata_s;
    end
  end

  // Sweep/state control, rearm tracking and registered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_CLEAR;
      clear_idx_r   <= {TABLE_ADDR_WIDTH{1'b0}};
      init_done     <= 1'b0;
      wr_disarm_r   <= 1'b0;
      rd_disarm_r   <= 1'b0;
      lookup_ack    <= 1'b0;
      lookup_data   <= {TABLE_ENTRY_WIDTH{1'b0}};
      table_wr_ack  <= 1'b0;
      table_rd_ack  <= 1'b0;
      table_rd_data <= {TABLE_ENTRY_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clear_idx_r <= clear_idx_r + IDX_ONE;
          if (clear_idx_r == LAST_IDX) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_CLEAR;
          clear_idx_r <= {TABLE_ADDR_WIDTH{1'b0}};
        end
      endcase

      init_done <= (state_r == ST_IDLE);

      // Lookups during the sweep are still answered, with zero data.
      lookup_ack <= lookup_req;
      if (lookup_grant_s) begin
        lookup_data <= rd_word_s[TABLE_ENTRY_WIDTH-1:0];
      end else if (lookup_req) begin
        lookup_data <= {TABLE_ENTRY_WIDTH{1'b0}};
      end

      table_wr_ack <= wr_grant_s;
      table_rd_ack <= rd_grant_s;
      if (rd_grant_s) begin
        table_rd_data <= rd_word_s[TABLE_ENTRY_WIDTH-1:0];
      end

      if (!table_wr_req) begin
        wr_disarm_r <= 1'b0;
      end else if (wr_grant_s) begin
        wr_disarm_r <= 1'b1;
      end
      if (!table_rd_req) begin
        rd_disarm_r <= 1'b0;
      end else if (rd_grant_s) begin
        rd_disarm_r <= 1'b1;
      end
    end
  end

`ifdef TABLE_STORE_PARITY_EN
  logic parity_err_r;

  // Flag a stored/recomputed parity mismatch alongside the matching ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= (lookup_grant_s || rd_grant_s) &&
                      (rd_word_s[RAM_W-1] != even_parity(rd_word_s[TABLE_ENTRY_WIDTH-1:0]));
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_generic_table_store.sv
// Self-checking bench for generic_table_store (TABLE_ADDR_WIDTH=4): random traffic against an array model
// of the table plus directed arbitration, rearm, reset and parity scenarios.
module tb_generic_table_store;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          table_rd_req, table_wr_req, lookup_req;
  logic          table_rd_ack, table_wr_ack, lookup_ack, init_done, parity_err;
  logic [AW-1:0] table_rd_addr, table_wr_addr, lookup_addr;
  logic [DW-1:0] table_rd_data, table_wr_data, lookup_data;

  logic [DW-1:0] model_mem [16];
  int            asserts  = 0;
  int            failures = 0;
  int            par_pulses = 0;

  generic_table_store #(.TABLE_ENTRY_WIDTH(DW), .TABLE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .table_rd_req(table_rd_req), .table_rd_ack(table_rd_ack),
    .table_rd_addr(table_rd_addr), .table_rd_data(table_rd_data),
    .table_wr_req(table_wr_req), .table_wr_ack(table_wr_ack),
    .table_wr_addr(table_wr_addr), .table_wr_data(table_wr_data),
    .lookup_req(lookup_req), .lookup_addr(lookup_addr),
    .lookup_ack(lookup_ack), .lookup_data(lookup_data),
    .init_done(init_done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err === 1'b1) par_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    return r[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  // Requester: hold req until ack, keep it one more cycle, drop it, then watch for stray acks.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int acks);
    bit seen = 0;
    acks = 0;
    table_wr_addr = a; table_wr_data = d; table_wr_req = 1'b1;
    for (int n = 0; n < BUDGET && !seen; n++) begin
      step();
      if (table_wr_ack) begin seen = 1; acks++; end
    end
    step();
    if (table_wr_ack) acks++;
    table_wr_req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (table_wr_ack) acks++;
    end
    if (seen) model_mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int acks);
    bit seen = 0;
    acks = 0;
    d = 'x;
    table_rd_addr = a; table_rd_req = 1'b1;
    for (int n = 0; n < BUDGET && !seen; n++) begin
      step();
      if (table_rd_ack) begin seen = 1; acks++; d = table_rd_data; end
    end
    step();
    if (table_rd_ack) acks++;
    table_rd_req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (table_rd_ack) acks++;
    end
  endtask

  task automatic apply_reset_and_wait_clear();
    reset = 1'b1;
    table_rd_req = 1'b0; table_wr_req = 1'b0; lookup_req = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (17) step();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    int acks;
    reset = 1'b1;
    table_rd_req = 1'b0; table_wr_req = 1'b0; lookup_req = 1'b0;
    table_rd_addr = 4'h0; table_wr_addr = 4'h0; table_wr_data = 8'h00; lookup_addr = 4'h0;
    repeat (3) step();
    asserts++;
    if ({table_rd_ack, table_wr_ack, lookup_ack, parity_err, init_done} !== 5'b0 ||
        table_rd_data !== 8'h00 || lookup_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_values: acks/perr/init=%b rd_data=%h lk_data=%h, required all 0",
               {table_rd_ack, table_wr_ack, lookup_ack, parity_err, init_done}, table_rd_data, lookup_data);
    end
    reset = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c == 4) begin lookup_req = 1'b1; lookup_addr = rnd_addr(); end
      step();
      lookup_req = 1'b0;
      if (c == 4) begin
        asserts++;
        if (lookup_ack !== 1'b1 || lookup_data !== 8'h00) begin
          failures++;
          $display("FAIL lookup_during_clear: ack=%b data=%h, required ack=1 data=00", lookup_ack, lookup_data);
        end
      end
      if (c == 16) begin
        asserts++;
        if (init_done !== 1'b0) begin
          failures++;
          $display("FAIL init_done_early: init_done=%b after 16 cycles, required 0", init_done);
        end
      end
      if (c == 17) begin
        asserts++;
        if (init_done !== 1'b1) begin
          failures++;
          $display("FAIL init_done_rise: init_done=%b after 17 cycles, required 1", init_done);
        end
      end
    end
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    do_read(4'd5, d, acks);
    asserts++;
    if (d !== 8'h00 || acks != 1) begin
      failures++;
      $display("FAIL read_after_clear: data=%h acks=%0d, required data=00 acks=1", d, acks);
    end
  endtask

  task automatic test_write_lookup();
    int acks;
    do_write(4'd3, 8'hA5, acks);
    asserts++;
    if (acks != 1) begin
      failures++;
      $display("FAIL write_single_ack: acks=%0d, required 1", acks);
    end
    lookup_req = 1'b1; lookup_addr = 4'd3;
    step();
    lookup_req = 1'b0;
    asserts++;
    if (lookup_ack !== 1'b1 || lookup_data !== 8'hA5) begin
      failures++;
      $display("FAIL lookup_idx3: ack=%b data=%h, required ack=1 data=a5", lookup_ack, lookup_data);
    end
    step();
    asserts++;
    if (lookup_ack !== 1'b0) begin
      failures++;
      $display("FAIL lookup_ack_pulse: ack=%b one cycle later, required 0", lookup_ack);
    end
  endtask

  // Lookup and register read issued in the cycle right after the write is granted.
  task automatic test_read_after_write();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit seen;
    for (int k = 0; k < 2; k++) begin
      a = rnd_addr(); d = rnd_data();
      seen = 0;
      table_wr_addr = a; table_wr_data = d; table_wr_req = 1'b1;
      for (int n = 0; n < BUDGET && !seen; n++) begin
        step();
        if (table_wr_ack) seen = 1;
      end
      if (seen) model_mem[a] = d;
      if (k == 0) begin lookup_req = 1'b1; lookup_addr = a; end
      else begin table_rd_req = 1'b1; table_rd_addr = a; end
      step();
      table_wr_req = 1'b0; lookup_req = 1'b0;
      asserts++;
      if (k == 0 && (!seen || lookup_ack !== 1'b1 || lookup_data !== model_mem[a])) begin
        failures++;
        $display("FAIL raw_lookup: wr_ack_seen=%0d ack=%b data=%h, required 1 1 %h", seen, lookup_ack, lookup_data, d);
      end else if (k == 1 && (!seen || table_rd_ack !== 1'b1 || table_rd_data !== model_mem[a])) begin
        failures++;
        $display("FAIL raw_read: wr_ack_seen=%0d ack=%b data=%h, required 1 1 %h", seen, table_rd_ack, table_rd_data, d);
      end
      step();
      table_rd_req = 1'b0;
      repeat (2) step();
    end
  endtask

  task automatic test_lookup_starve();
    logic [DW-1:0] oldv, newv;
    int lk_acks = 0, early_wr = 0, bad_data = 0;
    bit seen = 0;
    newv = rnd_data();
    oldv = model_mem[9];
    if (newv == oldv) newv = ~oldv;
    table_wr_addr = 4'd9; table_wr_data = newv; table_wr_req = 1'b1;
    lookup_req = 1'b1; lookup_addr = 4'd9;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 9) lookup_req = 1'b0;
      if (lookup_ack === 1'b1) lk_acks++;
      if (lookup_data !== oldv) bad_data++;
      if (table_wr_ack !== 1'b0) early_wr++;
    end
    asserts++;
    if (lk_acks != 10 || bad_data != 0 || early_wr != 0) begin
      failures++;
      $display("FAIL starve_lookups: lookup_acks=%0d bad_data=%0d early_wr_acks=%0d, required 10 0 0",
               lk_acks, bad_data, early_wr);
    end
    for (int n = 0; n < BUDGET && !seen; n++) begin
      step();
      if (table_wr_ack) seen = 1;
    end
    step();
    table_wr_req = 1'b0;
    if (seen) model_mem[9] = newv;
    asserts++;
    if (!seen) begin
      failures++;
      $display("FAIL starve_wr_ack: table_wr_ack never seen, required one ack after lookups stop");
    end
    step();
    lookup_req = 1'b1; lookup_addr = 4'd9;
    step();
    lookup_req = 1'b0;
    asserts++;
    if (lookup_ack !== 1'b1 || lookup_data !== newv) begin
      failures++;
      $display("FAIL starve_new_value: ack=%b data=%h, required ack=1 data=%h", lookup_ack, lookup_data, newv);
    end
  endtask

  task automatic test_wr_rd_same_cycle();
    int wr_cnt = 0, rd_cnt = 0, wr_at = 0, rd_at = 0;
    bit wr_seen = 0, rd_seen = 0;
    logic [DW-1:0] got = 'x;
    table_wr_addr = 4'd7; table_wr_data = 8'h3C; table_rd_addr = 4'd7;
    table_wr_req = 1'b1; table_rd_req = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (wr_seen) table_wr_req = 1'b0;
      if (rd_seen) table_rd_req = 1'b0;
      if (table_wr_ack) begin wr_cnt++; wr_seen = 1; wr_at = n; end
      if (table_rd_ack) begin rd_cnt++; rd_seen = 1; rd_at = n; got = table_rd_data; end
    end
    table_wr_req = 1'b0; table_rd_req = 1'b0;
    model_mem[7] = 8'h3C;
    asserts++;
    if (wr_cnt != 1 || rd_cnt != 1 || !(wr_at < rd_at) || got !== 8'h3C) begin
      failures++;
      $display("FAIL wr_rd_same: wr_acks=%0d rd_acks=%0d wr_at=%0d rd_at=%0d data=%h, required 1 1 wr<rd 3c",
               wr_cnt, rd_cnt, wr_at, rd_at, got);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d, got;
    int acks, op;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(2, 0);
      a = rnd_addr();
      if (op == 0) begin
        d = rnd_data();
        do_write(a, d, acks);
        asserts++;
        if (acks != 1) begin
          failures++;
          $display("FAIL rand_write[%0d]: acks=%0d, required 1", i, acks);
        end
      end else if (op == 1) begin
        do_read(a, got, acks);
        asserts++;
        if (acks != 1 || got !== model_mem[a]) begin
          failures++;
          $display("FAIL rand_read[%0d]: idx=%0d data=%h acks=%0d, required %h acks=1", i, a, got, acks, model_mem[a]);
        end
      end else begin
        lookup_req = 1'b1; lookup_addr = a;
        step();
        lookup_req = 1'b0;
        asserts++;
        if (lookup_ack !== 1'b1 || lookup_data !== model_mem[a]) begin
          failures++;
          $display("FAIL rand_lookup[%0d]: idx=%0d ack=%b data=%h, required ack=1 %h", i, a, lookup_ack, lookup_data, model_mem[a]);
        end
      end
    end
  endtask

  task automatic test_parity();
    int acks;
    logic [DW-1:0] got;
    do_write(4'd2, 8'h5A, acks);
`ifdef TABLE_STORE_PARITY_EN
    dut.mem_r[2][0] = ~dut.mem_r[2][0];
    model_mem[2] = 8'h5B;
    lookup_req = 1'b1; lookup_addr = 4'd2;
    step();
    lookup_req = 1'b0;
    asserts++;
    if (lookup_ack !== 1'b1 || parity_err !== 1'b1 || lookup_data !== 8'h5B) begin
      failures++;
      $display("FAIL parity_lookup: ack=%b perr=%b data=%h, required 1 1 5b", lookup_ack, parity_err, lookup_data);
    end
    step();
    asserts++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_pulse: perr=%b one cycle later, required 0", parity_err);
    end
    do_write(4'd2, 8'h5A, acks);
    lookup_req = 1'b1; lookup_addr = 4'd2;
    step();
    lookup_req = 1'b0;
    asserts++;
    if (parity_err !== 1'b0 || lookup_data !== 8'h5A) begin
      failures++;
      $display("FAIL parity_rewrite: perr=%b data=%h, required 0 5a", parity_err, lookup_data);
    end
`else
    lookup_req = 1'b1; lookup_addr = 4'd2;
    step();
    lookup_req = 1'b0;
    do_read(4'd2, got, acks);
    asserts++;
    if (par_pulses != 0 || got !== 8'h5A) begin
      failures++;
      $display("FAIL parity_disabled: parity_err pulses=%0d data=%h, required 0 pulses data=5a", par_pulses, got);
    end
`endif
  endtask

  task automatic test_reset_midop();
    int rd_acks = 0, acks;
    logic [DW-1:0] got;
    do_write(4'd3, 8'hC3, acks);
    lookup_req = 1'b1; lookup_addr = 4'd1;
    table_rd_req = 1'b1; table_rd_addr = 4'd3;
    repeat (3) begin
      step();
      if (table_rd_ack) rd_acks++;
    end
    reset = 1'b1; table_rd_req = 1'b0; lookup_req = 1'b0;
    repeat (2) begin
      step();
      if (table_rd_ack) rd_acks++;
    end
    reset = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (table_rd_ack) rd_acks++;
      if (c == 16) begin
        asserts++;
        if (init_done !== 1'b0) begin
          failures++;
          $display("FAIL midop_sweep_restart: init_done=%b 16 cycles after reset, required 0", init_done);
        end
      end
    end
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    asserts++;
    if (rd_acks != 0 || init_done !== 1'b1) begin
      failures++;
      $display("FAIL midop_no_ack: rd_acks=%0d init_done=%b, required 0 1", rd_acks, init_done);
    end
    do_read(4'd3, got, acks);
    asserts++;
    if (got !== 8'h00 || acks != 1) begin
      failures++;
      $display("FAIL midop_cleared: data=%h acks=%0d, required 00 1", got, acks);
    end
  endtask

  initial begin
    test_reset();
    test_write_lookup();
    test_read_after_write();
    test_lookup_starve();
    test_wr_rd_same_cycle();
    test_random();
    test_parity();
    test_reset_midop();
    apply_reset_and_wait_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
